// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and the write-back queue entry type for the register-file write arbiter.
package rf_write_arbiter_pkg;
  localparam int RF_DEPTH  = 4;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                 valid;
    logic                 kill;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Source/result bundle of the register-file write arbiter: pipeline, aux handshake, RF write port, hazard query.
interface rf_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              aux_valid;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_data;
  logic              aux_ready;
  logic              RegWrite;
  logic [ADDR_W-1:0] Write_register;
  logic [DATA_W-1:0] Write_data;
  logic [CNT_W-1:0]  queue_count;
  logic [ADDR_W-1:0] busy_query;
  logic              busy_hit;

  modport master (
    output pipe_we, pipe_addr, pipe_data, aux_valid, aux_addr, aux_data, busy_query,
    input  aux_ready, RegWrite, Write_register, Write_data, queue_count, busy_hit
  );

  modport slave (
    input  pipe_we, pipe_addr, pipe_data, aux_valid, aux_addr, aux_data, busy_query,
    output aux_ready, RegWrite, Write_register, Write_data, queue_count, busy_hit
  );
endinterface

// File: rtl/rf_wb_fifo.sv
// Circular write-back queue with per-entry kill-by-address; pointers carry an extra wrap bit.
// RF_ARB_SCOREBOARD_EN adds the per-entry pending-write query comparators.
module rf_wb_fifo
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH = RF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [RF_ADDR_W-1:0]      push_addr,
  input  logic [RF_DATA_W-1:0]      push_data,
  input  logic                      pop,
  input  logic                      kill_en,
  input  logic [RF_ADDR_W-1:0]      kill_addr,
  output wb_entry_t                 head,
  output logic [$clog2(DEPTH):0]    count
`ifdef RF_ARB_SCOREBOARD_EN
  ,
  input  logic [RF_ADDR_W-1:0]      query_addr,
  output logic                      query_hit
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  kill_hit;
  logic              full, empty;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == CW'(DEPTH));
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[PW-1:0]];

`ifdef RF_ARB_SCOREBOARD_EN
  logic [DEPTH-1:0] query_match;
  assign query_hit = |query_match;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign kill_hit[i] = kill_en && mem_q[i].valid && (mem_q[i].addr == kill_addr);
`ifdef RF_ARB_SCOREBOARD_EN
    assign query_match[i] = mem_q[i].valid && !mem_q[i].kill && (mem_q[i].addr == query_addr);
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (kill_hit[i]) mem_d[i].kill = 1'b1;
    end
    if (pop && !empty) begin
      mem_d[rd_ptr_q[PW-1:0]].valid = 1'b0;
      mem_d[rd_ptr_q[PW-1:0]].kill  = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // The slot just freed by a pop is never the tail slot unless the queue was full.
    if (push && !full) begin
      mem_d[wr_ptr_q[PW-1:0]] = '{valid: 1'b1, kill: 1'b0, addr: push_addr, data: push_data};
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback and a queued multi-cycle source onto one registered RF write port.
// Define RF_ARB_SCOREBOARD_EN to compile in the busy_hit pending-write query.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int DEPTH  = RF_DEPTH,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  rf_write_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              pipe_sel, aux_acc, aux_keep, bypass, push, pop;
  wb_entry_t         head;
  logic [CNT_W-1:0]  count;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

`ifdef RF_ARB_SCOREBOARD_EN
  logic fifo_hit;
`endif

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (bus.aux_addr),
    .push_data (bus.aux_data),
    .pop       (pop),
    .kill_en   (pipe_sel),
    .kill_addr (bus.pipe_addr),
    .head      (head),
    .count     (count)
`ifdef RF_ARB_SCOREBOARD_EN
    ,
    .query_addr(bus.busy_query),
    .query_hit (fifo_hit)
`endif
  );

  // The pipeline write is the youngest producer: same-address aux beats are dropped on arrival.
  always_comb begin
    pipe_sel = bus.pipe_we && (bus.pipe_addr != REG_ZERO);
    aux_acc  = bus.aux_valid && bus.aux_ready;
    aux_keep = aux_acc && (bus.aux_addr != REG_ZERO) &&
               !(pipe_sel && (bus.aux_addr == bus.pipe_addr));
    pop      = !pipe_sel && head.valid;
    bypass   = !pipe_sel && !head.valid && aux_keep;
    push     = aux_keep && !bypass;
  end

  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    if (pipe_sel) begin
      regwrite_d = 1'b1;
      wreg_d     = bus.pipe_addr;
      wdata_d    = bus.pipe_data;
    end else if (pop) begin
      // A killed head still burns its drain slot, but writes nothing.
      if (!head.kill) begin
        regwrite_d = 1'b1;
        wreg_d     = head.addr;
        wdata_d    = head.data;
      end
    end else if (bypass) begin
      regwrite_d = 1'b1;
      wreg_d     = bus.aux_addr;
      wdata_d    = bus.aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.aux_ready      = (count < CNT_W'(DEPTH));
  assign bus.queue_count    = count;
  assign bus.RegWrite       = regwrite_q;
  assign bus.Write_register = wreg_q;
  assign bus.Write_data     = wdata_q;

`ifdef RF_ARB_SCOREBOARD_EN
  assign bus.busy_hit = (bus.busy_query != REG_ZERO) &&
                        (fifo_hit || (regwrite_q && (wreg_q == bus.busy_query)));
`else
  logic unused_query;
  assign unused_query = ^bus.busy_query;
  assign bus.busy_hit = 1'b0;
`endif
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: per-cycle vector table plus a randomized aux burst checked by a write scoreboard.
module tb_rf_write_arbiter;
  localparam int DEPTH = 4, AW = 5, DW = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rf_write_arbiter_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();
  rf_write_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic rst, pwe, av, we, rdy, hit;
    logic [AW-1:0] pa, aa, bq, wr;
    logic [DW-1:0] pd, ad, wd;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  logic [AW+DW-1:0] exp_w[$];
  logic [AW+DW-1:0] aux_exp[$];
  int nvec = 0, nerr = 0;
  bit mon_en = 1'b0;

  function automatic vec_t mk(input int rst, pwe, pa, pd, av, aa, ad, bq,
                              input int we, wr, wd, cnt, rdy, hit);
    vec_t v;
    v.rst = 1'(rst); v.pwe = 1'(pwe); v.pa = AW'(pa); v.pd = DW'(pd);
    v.av = 1'(av); v.aa = AW'(aa); v.ad = DW'(ad); v.bq = AW'(bq);
    v.we = 1'(we); v.wr = AW'(wr); v.wd = DW'(wd); v.cnt = 3'(cnt);
    v.rdy = 1'(rdy); v.hit = 1'(hit);
    return v;
  endfunction

  task automatic check(input vec_t e, input int row);
    logic exp_hit;
`ifdef RF_ARB_SCOREBOARD_EN
    exp_hit = e.hit;
`else
    exp_hit = 1'b0;
`endif
    nvec++;
    if (bus.RegWrite !== e.we || bus.Write_register !== e.wr || bus.Write_data !== e.wd ||
        bus.queue_count !== e.cnt || bus.aux_ready !== e.rdy || bus.busy_hit !== exp_hit) begin
      nerr++;
      $display("FAIL row%0d got we=%b wr=%0d wd=%h cnt=%0d rdy=%b hit=%b, want we=%b wr=%0d wd=%h cnt=%0d rdy=%b hit=%b",
               row, bus.RegWrite, bus.Write_register, bus.Write_data, bus.queue_count,
               bus.aux_ready, bus.busy_hit, e.we, e.wr, e.wd, e.cnt, e.rdy, exp_hit);
    end
  endtask

  task automatic apply(input vec_t v, input int row);
    @(negedge clk);
    reset = v.rst;
    bus.pipe_we = v.pwe; bus.pipe_addr = v.pa; bus.pipe_data = v.pd;
    bus.aux_valid = v.av; bus.aux_addr = v.aa; bus.aux_data = v.ad;
    bus.busy_query = v.bq;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check(sb.pop_front(), row);
  endtask

  // Write scoreboard for the burst sequence: every RF write must match the queue head.
  always @(negedge clk) begin
    if (mon_en && bus.RegWrite === 1'b1) begin
      nvec++;
      if (exp_w.size() == 0) begin
        nerr++;
        $display("FAIL burst_write unexpected got wr=%0d wd=%h, want no write",
                 bus.Write_register, bus.Write_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_w.pop_front();
        if ({bus.Write_register, bus.Write_data} !== e) begin
          nerr++;
          $display("FAIL burst_write got wr=%0d wd=%h, want wr=%0d wd=%h",
                   bus.Write_register, bus.Write_data, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    int a, beat;
    bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0;
    bus.aux_valid = 0; bus.aux_addr = 0; bus.aux_data = 0; bus.busy_query = 0;

    //               rst pwe pa  pd      av aa  ad     bq | we wr  wd      cnt rdy hit
    tbl.push_back(mk(1,  0,  0,  0,      0, 0,  0,     0,   0, 0,  0,      0, 1, 0));
    tbl.push_back(mk(0,  1,  3,  'h11,   0, 0,  0,     0,   1, 3,  'h11,   0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 3,  'h11,   0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      1, 7,  'hAB,  0,   1, 7,  'hAB,   0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 7,  'hAB,   0, 1, 0));
    for (int i = 0; i < 6; i++) begin
      a = (i < 4) ? 8 + i : 12;
      tbl.push_back(mk(0, 1, 20 + i, 'h120 + i, 1, a, 'h80 + a, 0,
                       1, 20 + i, 'h120 + i, (i < 4) ? i + 1 : 4, (i < 3) ? 1 : 0, 0));
    end
    tbl.push_back(mk(0,  0,  0,  0,      1, 12, 'h8C,  0,   1, 8,  'h88,   3, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      1, 12, 'h8C,  0,   1, 9,  'h89,   3, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   1, 10, 'h8A,   2, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   1, 11, 'h8B,   1, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   1, 12, 'h8C,   0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 12, 'h8C,   0, 1, 0));
    tbl.push_back(mk(0,  1,  0,  'h55,   1, 0,  'h66,  0,   0, 12, 'h8C,   0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 12, 'h8C,   0, 1, 0));
    tbl.push_back(mk(0,  1,  30, 'h130,  1, 5,  'h1,   0,   1, 30, 'h130,  1, 1, 0));
    tbl.push_back(mk(0,  1,  5,  'h2,    0, 0,  0,     0,   1, 5,  'h2,    1, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 5,  'h2,    0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 5,  'h2,    0, 1, 0));
    tbl.push_back(mk(0,  1,  6,  'h3,    1, 6,  'h4,   0,   1, 6,  'h3,    0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 6,  'h3,    0, 1, 0));
    tbl.push_back(mk(0,  1,  31, 'h131,  1, 9,  'h99,  9,   1, 31, 'h131,  1, 1, 1));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     9,   1, 9,  'h99,   0, 1, 1));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     9,   0, 9,  'h99,   0, 1, 0));
    tbl.push_back(mk(0,  1,  1,  'h201,  1, 13, 'hD,   0,   1, 1,  'h201,  1, 1, 0));
    tbl.push_back(mk(0,  1,  2,  'h202,  1, 14, 'hE,   0,   1, 2,  'h202,  2, 1, 0));
    tbl.push_back(mk(0,  1,  3,  'h203,  1, 15, 'hF,   0,   1, 3,  'h203,  3, 1, 0));
    tbl.push_back(mk(1,  0,  0,  0,      0, 0,  0,     0,   0, 0,  0,      0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 0,  0,      0, 1, 0));
    tbl.push_back(mk(0,  0,  0,  0,      0, 0,  0,     0,   0, 0,  0,      0, 1, 0));

    foreach (tbl[i]) apply(tbl[i], i);

    // Burst: pipeline busy for 3 cycles while 6 aux beats trickle in with random gaps.
    mon_en = 1'b1;
    beat = 0;
    for (int c = 0; c < 60 && (beat < 6 || c < 3); c++) begin
      @(negedge clk);
      if (c == 3) while (aux_exp.size() != 0) exp_w.push_back(aux_exp.pop_front());
      bus.pipe_we   = (c < 3);
      bus.pipe_addr = AW'(26 + c);
      bus.pipe_data = DW'(32'h400 + c);
      if (c < 3) exp_w.push_back({AW'(26 + c), DW'(32'h400 + c)});
      bus.aux_valid = (beat < 6) && ($urandom_range(0, 3) != 0);
      bus.aux_addr  = AW'(16 + beat);
      bus.aux_data  = DW'(32'h300 + beat);
      if (bus.aux_valid && bus.aux_ready === 1'b1) begin
        if (c < 3) aux_exp.push_back({bus.aux_addr, bus.aux_data});
        else       exp_w.push_back({bus.aux_addr, bus.aux_data});
        beat++;
      end
    end
    @(negedge clk);
    bus.pipe_we = 0; bus.aux_valid = 0;
    while (aux_exp.size() != 0) exp_w.push_back(aux_exp.pop_front());
    nvec++;
    if (beat != 6) begin
      nerr++;
      $display("FAIL burst_beats got %0d accepted, want 6", beat);
    end
    for (int k = 0; k < 30 && exp_w.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    nvec++;
    if (exp_w.size() != 0) begin
      nerr++;
      $display("FAIL burst_drain got %0d writes outstanding, want 0", exp_w.size());
    end
    nvec++;
    if (bus.queue_count !== 3'd0) begin
      nerr++;
      $display("FAIL burst_count got %0d, want 0", bus.queue_count);
    end
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Write-side front end for the register file's single write port.
- Merges two result sources onto one registered write port (RegWrite/Write_register/Write_data):
  - the in-order pipeline writeback stage, which never stalls;
  - a multi-cycle unit (mult/div, cache-miss load) with a valid/ready handshake.
- Multi-cycle results are buffered in a small FIFO and drained on idle pipeline cycles.
- Optional scoreboard query reports pending writes to the hazard unit.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 5, register address width
- DATA_W, 32, write data width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- pipe_we  in  1  pipeline writeback request
- pipe_addr  in  ADDR_W  pipeline destination register
- pipe_data  in  DATA_W  pipeline result
- aux_valid  in  1  multi-cycle result valid
- aux_addr  in  ADDR_W  multi-cycle destination register
- aux_data  in  DATA_W  multi-cycle result
- aux_ready  out  1  FIFO can accept; equals count < DEPTH
- RegWrite  out  1  register-file write enable (registered)
- Write_register  out  ADDR_W  write address (registered)
- Write_data  out  DATA_W  write data (registered)
- queue_count  out  $clog2(DEPTH)+1  occupied FIFO entries
- busy_query  in  ADDR_W  register probed by hazard unit
- busy_hit  out  1  a write to busy_query is pending

Behaviour:
- Clock and reset:
  - Single clock, clk; reset is synchronous and active-high, sampled on posedge clk.
  - Reset empties the FIFO (all valid and kill bits cleared, pointers = 0).
  - Reset values: RegWrite=0, Write_register=0, Write_data=0, queue_count=0, aux_ready=1.
  - Reset mid-drain discards all queued entries with no write.
- Address 0 handling:
  - pipe_we with pipe_addr=0 is ignored.
  - An aux beat with aux_addr=0 is accepted (handshake completes) and discarded without being enqueued.
- Per-cycle source selection, priority high to low:
  1. pipeline write, if pipe_we and pipe_addr≠0;
  2. FIFO head, if not empty;
  3. aux direct bypass, if FIFO empty and an aux beat is accepted this cycle.
- Output timing:
  - The selected write loads the output register; it appears on RegWrite/Write_* one cycle after selection.
  - If nothing is selected, the next cycle has RegWrite=0 and Write_register/Write_data hold their previous values.
- Aux acceptance:
  - A beat is accepted when aux_valid && aux_ready.
  - If it is not bypassed, it is pushed at the tail.
  - A push and a pop may occur in the same cycle.
  - When the FIFO is full, aux_ready=0 even if a pop occurs that cycle; no push-through at full.
- Ordering, where the pipeline write is treated as younger:
  - A selected pipeline write to address A sets the kill bit of every valid FIFO entry with address A.
  - An aux beat to A accepted in the same cycle is accepted and discarded.
- Killed entries:
  - A killed entry is still popped in FIFO order.
  - Its pop cycle yields RegWrite=0 next cycle and consumes the drain slot.
- queue_count: occupancy after the current edge, registered; wraps correctly via an extra MSB on the pointers.
- busy_hit (combinational):
  - Set when busy_query≠0 and it matches any valid, unkilled FIFO entry, or matches Write_register while RegWrite=1.
  - Otherwise 0.

Optional Feature:
- Macro: RF_ARB_SCOREBOARD_EN.
- When defined: the busy_hit logic above is compiled in.
- When undefined: busy_query is unused, busy_hit is tied 0, and the per-entry address comparators for the query are removed. Kill logic remains in both builds.

Decomposition:
- Shared package constants: REG_ZERO (5'd0), ADDR_W/DATA_W defaults, and a wb_entry_t struct {valid, kill, addr, data}.
- Sub-module: rf_wb_fifo, the circular buffer with push/pop/count plus a kill-by-address input.
- The top level holds the priority mux, output register and scoreboard.

Test Plan:
- Reset, then pipe_we=1, addr=3, data=0x11 -> next cycle RegWrite=1, Write_register=3, Write_data=0x11; queue_count=0.
- FIFO empty, pipe_we=0, aux beat addr=7, data=0xAB -> bypass; next cycle RegWrite=1, Write_register=7, Write_data=0xAB; queue_count stays 0.
- pipe_we held 1 for 6 cycles while aux sends 5 beats (addr 8..12):
  - aux_ready drops after 4 beats, queue_count=4;
  - after pipe_we falls, entries drain in order 8..11, one per cycle, then beat 12.
- Queue aux addr=5 data=0x1, then pipe write addr=5 data=0x2 -> final RF write sequence is only 0x2 to r5; the killed entry's drain cycle shows RegWrite=0.
- aux addr=0 and pipe addr=0 -> handshake completes, no enqueue, RegWrite stays 0.
- With RF_ARB_SCOREBOARD_EN:
  - queued r9, busy_query=9 -> busy_hit=1;
  - after r9 is written out and RegWrite deasserts, busy_hit=0;
  - reset asserted with 3 queued entries -> queue_count=0 and no writes occur afterwards.
